// File: rtl/da_z2_bit_serial_mac_if.sv
// Handshake and ROM-lookup bundle for the z2 bit-serial DA MAC.
// Both handshakes: a transfer happens on a rising clk edge where valid && ready; the
// sender holds its data stable while valid is high and ready is low.
interface da_z2_bit_serial_mac_if #(
  parameter int DATA_W = 16,
  parameter int ROM_W  = 16,
  parameter int ACC_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] x2;
  logic [DATA_W-1:0] x3;
  logic              rom_cs;
  logic [2:0]        rom_addr;
  logic [ROM_W-1:0]  rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;

  modport slave (
    input  in_valid, x1, x2, x3, rom_data, out_ready,
    output in_ready, rom_cs, rom_addr, out_valid, out_data
  );

  modport master (
    output in_valid, x1, x2, x3, rom_data, out_ready,
    input  in_ready, rom_cs, rom_addr, out_valid, out_data
  );
endinterface

// File: rtl/da_z2_bit_serial_mac.sv
// Bit-serial distributed-arithmetic MAC for the z2 DCT row: LSB-first ROM lookups, shift-accumulate.
// Optional DA_ROUND_EN: round the Q.14 result half-up to integer and saturate to DATA_W.
module da_z2_bit_serial_mac #(
  parameter int DATA_W = 16,
  parameter int ROM_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  da_z2_bit_serial_mac_if.slave  bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int JW = $clog2(DATA_W);
  localparam logic [JW-1:0] LAST_J = JW'(DATA_W - 1);

  state_t                    state_q, state_d;
  logic [JW-1:0]             j_q, j_d;
  logic [DATA_W-1:0]         sr1_q, sr1_d, sr2_q, sr2_d, sr3_q, sr3_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   out_data_q, out_data_d;
  logic signed [ACC_W-1:0]   rom_ext;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_fin;

  function automatic logic signed [ACC_W-1:0] finalize(input logic signed [ACC_W-1:0] a);
`ifdef DA_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << 13);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;
    logic signed [ACC_W-1:0] r;
    r = (a + RND_HALF) >>> 14;
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end
    return r;
`else
    return a;
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    sr1_d      = sr1_q;
    sr2_d      = sr2_q;
    sr3_d      = sr3_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    rom_ext    = {{(ACC_W - ROM_W){bus.rom_data[ROM_W-1]}}, bus.rom_data};
    term       = rom_ext <<< j_q;
    acc_fin    = acc_q - term;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sr1_d   = bus.x1;
          sr2_d   = bus.x2;
          sr3_d   = bus.x3;
          acc_d   = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sr1_d = sr1_q >> 1;
        sr2_d = sr2_q >> 1;
        sr3_d = sr3_q >> 1;
        // The sign-bit slice carries negative weight in two's complement.
        if (j_q == LAST_J) begin
          acc_d      = acc_fin;
          out_data_d = finalize(acc_fin);
          state_d    = DONE;
        end else begin
          acc_d = acc_q + term;
          j_d   = j_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      j_q        <= '0;
      sr1_q      <= '0;
      sr2_q      <= '0;
      sr3_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      sr1_q      <= sr1_d;
      sr2_q      <= sr2_d;
      sr3_q      <= sr3_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.rom_cs    = (state_q == RUN);
  assign bus.rom_addr  = (state_q == RUN) ? {sr1_q[0], sr2_q[0], sr3_q[0]} : 3'b000;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_da_z2_bit_serial_mac.sv
// Directed bench for the z2 DA MAC with a combinational z2 ROM model and a result scoreboard.
module tb_da_z2_bit_serial_mac;
  localparam int DATA_W = 16;
  localparam int ROM_W  = 16;
  localparam int ACC_W  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  da_z2_bit_serial_mac_if #(.DATA_W(DATA_W), .ROM_W(ROM_W), .ACC_W(ACC_W)) bus ();

  da_z2_bit_serial_mac #(.DATA_W(DATA_W), .ROM_W(ROM_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [ACC_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] cur1 = '0, cur2 = '0, cur3 = '0;
  int accept_cyc = 0;
  int run_cnt = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // z2 ROM: addr {a1,a2,a3} -> a1*6270 + a2*(-6270) + a3*(-15137), Q2.14.
  function automatic logic [ROM_W-1:0] rom_lut(input logic [2:0] a);
    case (a)
      3'd0:    return 16'h0000;
      3'd1:    return 16'hC4DF;
      3'd2:    return 16'hE782;
      3'd3:    return 16'hAC61;
      3'd4:    return 16'h187E;
      3'd5:    return 16'hDD5D;
      3'd6:    return 16'h0000;
      default: return 16'hC4DF;
    endcase
  endfunction

  assign bus.rom_data = rom_lut(bus.rom_addr);

  function automatic logic [31:0] exp_of(input int raw);
`ifdef DA_ROUND_EN
    int r;
    r = (raw + 8192) >>> 14;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: rom_addr sequence, latency, and scoreboard pop on every result handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rom_cs) begin
        if (run_cnt < DATA_W)
          chk("rom_addr", {29'd0, bus.rom_addr}, {29'd0, cur1[run_cnt], cur2[run_cnt], cur3[run_cnt]});
        else
          chk("run_too_long", run_cnt, DATA_W - 1);
        run_cnt++;
      end
      if (bus.in_ready) run_cnt = 0;
      chk("in_ready_with_out_valid", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
      if (bus.out_valid && !ov_prev) begin
        chk("latency", cyc - accept_cyc, DATA_W);
        chk("run_len", run_cnt, DATA_W);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", bus.out_data, 32'hDEAD_BEEF);
        else chk("out_data", bus.out_data, exp_q.pop_front());
      end
      ov_prev = bus.out_valid;
    end else begin
      ov_prev = 1'b0;
      run_cnt = 0;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input int raw, input bit push);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.x1 = a;
    bus.x2 = b;
    bus.x3 = c;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", n, 0);
      bus.in_valid = 1'b0;
      return;
    end
    cur1 = a;
    cur2 = b;
    cur3 = c;
    if (push) exp_q.push_back(exp_of(raw));
    @(posedge clk); #1;
    accept_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.x1        = '0;
    bus.x2        = '0;
    bus.x3        = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_rom_cs",    {31'd0, bus.rom_cs},    32'd0);
    chk("rst_rom_addr",  {29'd0, bus.rom_addr},  32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data",  bus.out_data,           32'd0);
    chk("rst_state",     {30'd0, dbg_state},     32'd0);
    @(negedge clk) rst = 1'b0;

    send(16'd0, 16'd0, 16'd0, 0, 1'b1);
    send(16'd0, 16'd0, 16'd1, -15137, 1'b1);
    send(16'd0, 16'd0, 16'hFFFF, 15137, 1'b1);
    // Back-to-back: the second triple waits with in_valid high while the block is busy.
    send(16'd1, 16'd0, 16'd1, -8867, 1'b1);
    send(16'd0, 16'd1, 16'd0, -6270, 1'b1);
    drain();

    bus.out_ready = 1'b0;
    send(16'd0, 16'd0, 16'd2, -30274, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_out_data",  bus.out_data,           exp_of(-30274));
      chk("stall_in_ready",  {31'd0, bus.in_ready},  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_hs_out_data",  bus.out_data,           exp_of(-30274));
    chk("stall_drained",     exp_q.size(),           0);

    send(16'd0, 16'd0, 16'd1, 0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_rom_cs", {31'd0, bus.rom_cs}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rom_cs",    {31'd0, bus.rom_cs},    32'd0);
    chk("abort_rom_addr",  {29'd0, bus.rom_addr},  32'd0);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_out_data",  bus.out_data,           32'd0);
    chk("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(negedge clk) rst = 1'b0;
    send(16'd0, 16'd0, 16'd1, -15137, 1'b1);
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/da_z2_bit_serial_mac.md
Name: da_z2_bit_serial_mac

Overview:
- Distributed-arithmetic (DA) multiply-accumulate stage for the z2 row of the 8-point DCT.
- Accepts three signed samples (x1, x2, x3) over a valid/ready handshake and bit-slices them LSB-first into a 3-bit address for the z2 coefficient ROM.
- Consumes the ROM's 16-bit Q2.14 partial sums, shift-accumulates them into the z2 coefficient, and presents the result over an output valid/ready handshake.
- Sits between the butterfly/sample-pairing stage (upstream) and the z2 ROM (lookup) / coefficient collector (downstream).

Parameters:
- DATA_W, 16, sample width in bits; also the number of bit-serial cycles.
- ROM_W, 16, ROM data width, signed Q2.14.
- ACC_W, 32, accumulator and output width; must be >= DATA_W+ROM_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  sample triple valid.
- in_ready  out  1  block can accept a triple.
- x1  in  DATA_W  signed sample 1.
- x2  in  DATA_W  signed sample 2.
- x3  in  DATA_W  signed sample 3.
- rom_cs  out  1  ROM chip select.
- rom_addr  out  3  ROM address {x1[j], x2[j], x3[j]}.
- rom_data  in  ROM_W  signed ROM partial sum, combinational response to rom_addr.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  signed z2 result.

Behaviour:
- Clock and reset: one clock, clk; reset is rst, asynchronous and active-high. Assertion takes effect immediately; deassertion is sampled on clk.
- Reset values: state=IDLE, in_ready=1, rom_cs=0, rom_addr=0, out_valid=0, out_data=0, accumulator=0, bit counter=0, shift registers=0.
- FSM IDLE:
  - in_ready=1, rom_cs=0.
  - On in_valid&in_ready: latch x1/x2/x3 into shift registers, clear accumulator and counter j, go to RUN.
- FSM RUN (exactly DATA_W cycles, j=0..DATA_W-1):
  - rom_cs=1, in_ready=0.
  - rom_addr is driven combinationally from the registered shift-register LSBs.
  - Each cycle, sext(rom_data) is sampled the same cycle.
  - For j<DATA_W-1: acc += sext(rom_data)<<j.
  - For j=DATA_W-1 (sign bit): acc -= sext(rom_data)<<(DATA_W-1).
  - Shift registers shift right by 1 and j increments.
  - After the j=DATA_W-1 update, register out_data=acc final value and go to DONE.
- FSM DONE:
  - out_valid=1, rom_cs=0, in_ready=0.
  - out_data is held stable until out_valid&out_ready.
  - On out_valid&out_ready: go to IDLE next cycle; out_valid drops, out_data retains its value.
- Latency: accept at edge t; RUN occupies cycles t+1..t+DATA_W; out_valid is high from cycle t+DATA_W+1. Throughput is one triple per DATA_W+2 cycles minimum.
- Arithmetic:
  - All arithmetic is two's complement at ACC_W; no overflow is possible at the defaults.
  - The raw result is Q(ACC_W-14).14.
- Boundary conditions:
  - in_valid while busy is ignored (in_ready=0), and the inputs are not sampled.
  - out_ready held low stalls the block in DONE indefinitely, with no data loss.
  - rst mid-RUN or mid-DONE aborts the operation; all outputs return to reset values; the pending result is discarded.
  - The ROM's own reset-sync gating (data=0 for one cycle after reset) is harmless, because RUN cannot begin before the first accept edge.
  - A new triple is never accepted in the same cycle as the result handshake.

Optional Feature:
- DA_ROUND_EN defined:
  - Before being registered into out_data, the final acc is rounded half-up to integer: (acc + 2^13) >>> 14.
  - It is then saturated to the signed DATA_W range [-32768, 32767] and sign-extended to ACC_W.
  - Latency is unchanged.
- DA_ROUND_EN undefined: out_data carries the raw Q.14 accumulator.

Test Plan:
1. Reset, then x1=x2=x3=0 -> rom_addr=0 for 16 RUN cycles; out_valid at t+17; out_data=0.
2. x1=0, x2=0, x3=1 -> addr=001 at j=0 only, rom_data=0xC4DF; out_data=-15137 (raw), or -1 with DA_ROUND_EN.
3. x1=0, x2=0, x3=-1 (0xFFFF) -> addr=001 every cycle; sign-bit subtraction gives out_data=+15137 (raw).
4. x1=1, x2=0, x3=1 then x1=0, x2=1, x3=0 back-to-back, out_ready=1 -> out_data=-8867 (ROM 0xDD5D) then -6270 (ROM 0xE782); second in_ready rises only after the first result handshake.
5. x3=2, out_ready=0 for 10 cycles after out_valid -> out_valid and out_data=-30274 held stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
6. rst pulsed at RUN j=7 -> rom_cs, out_valid and out_data go to 0 immediately; block back in IDLE with in_ready=1; next triple x3=1 yields -15137.
